// File: rtl/eth_rx_pkg.sv
// Shared state encoding and Ethernet preamble/SFD constants for the GMII receive aligner.
package eth_rx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    PAYLOAD  = 2'd2,
    DROP     = 2'd3
  } rx_state_t;

  localparam logic [7:0] ETH_PRE     = 8'h55;
  localparam logic [7:0] ETH_SFD     = 8'hD5;
  localparam logic [3:0] MII_PRE_NIB = 4'h5;
  localparam logic [3:0] MII_SFD_NIB = 4'hD;

  localparam int PRE_CNT_W = 8;

endpackage

// File: rtl/mii_nibble_pack.sv
// Packs 10/100 MII nibbles into bytes, low nibble first; the byte is presented on the high nibble.
module mii_nibble_pack (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] nibble,
  input  logic       valid,
  input  logic       phase_clear,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       odd_pending
);

  logic       phase;
  logic [3:0] low_nib;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 1'b0;
    end else if (phase_clear) begin
      phase <= 1'b0;
    end else if (valid) begin
      phase <= ~phase;
    end
  end

  always_ff @(posedge clk) begin
    if (valid && !phase) begin
      low_nib <= nibble;
    end
  end

  assign byte_data   = {nibble, low_nib};
  assign byte_valid  = valid & phase;
  assign odd_pending = phase;

endmodule

// File: rtl/gmii_rx_frame_align.sv
// GMII/MII receive aligner: strips preamble/SFD and emits payload as a non-stallable AXI stream.
// Optional statistics counters are enabled by defining GMII_RX_STATS_EN.
module gmii_rx_frame_align
  import eth_rx_pkg::*;
#(
  parameter int PRE_CHECK     = 1,
  parameter int MAX_PRE_BYTES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mii_select,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        start_packet,
  output logic        error_preamble,
`ifdef GMII_RX_STATS_EN
  output logic        error_bad_frame,
  output logic [31:0] stat_frames,
  output logic [31:0] stat_bad_frames
`else
  output logic        error_bad_frame
`endif
);

  rx_state_t state, state_next;

  logic [7:0]           rxd_p0;
  logic                 dv_p0, er_p0, mii_p0, loaded_p0;
  logic                 armed, mode_mii, prev5, err_flag;
  logic [PRE_CNT_W-1:0] pre_cnt;
  logic [7:0]           hold_p1;
  logic                 vld_p1;

  logic                 eval_mii, is_pre, is_sfd, pre_bad, pre_go;
  logic [PRE_CNT_W:0]   cnt_inc, pre_limit;
  logic [7:0]           pack_byte, new_byte;
  logic                 pack_valid, pack_done, odd_pending, byte_done, bad_end;
  logic                 tvalid_d, tlast_d, tuser_d, start_d, epre_d, ebad_d;
  logic [7:0]           tdata_d;
  logic                 hold_load, hold_clr;

  // Stage p0: input register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_p0     <= 1'b0;
      er_p0     <= 1'b0;
      mii_p0    <= 1'b0;
      loaded_p0 <= 1'b0;
    end else begin
      dv_p0     <= gmii_rx_dv;
      er_p0     <= gmii_rx_er;
      mii_p0    <= mii_select;
      loaded_p0 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    rxd_p0 <= gmii_rxd;
  end

  assign pack_valid = dv_p0 & (state == PAYLOAD) & mode_mii;

  mii_nibble_pack u_pack (
    .clk         (clk),
    .rst_n       (rst_n),
    .nibble      (rxd_p0[3:0]),
    .valid       (pack_valid),
    .phase_clear (state != PAYLOAD),
    .byte_data   (pack_byte),
    .byte_valid  (pack_done),
    .odd_pending (odd_pending)
  );

  // Mode is taken live on the first unit of a frame, then held from the latched copy.
  assign eval_mii  = (state == IDLE) ? mii_p0 : mode_mii;
  assign is_pre    = eval_mii ? (rxd_p0[3:0] == MII_PRE_NIB) : (rxd_p0 == ETH_PRE);
  assign is_sfd    = eval_mii ? ((state == PREAMBLE) && prev5 && (rxd_p0[3:0] == MII_SFD_NIB))
                              : (rxd_p0 == ETH_SFD);
  assign cnt_inc   = {1'b0, pre_cnt} + {{PRE_CNT_W{1'b0}}, 1'b1};
  assign pre_limit = eval_mii ? (PRE_CNT_W+1)'(2 * MAX_PRE_BYTES) : (PRE_CNT_W+1)'(MAX_PRE_BYTES);
  assign pre_bad   = er_p0 | ((PRE_CHECK != 0) & ~is_pre & ~is_sfd) | (~is_sfd & (cnt_inc > pre_limit));
  assign pre_go    = dv_p0 & ((state == PREAMBLE) | ((state == IDLE) & armed));

  assign byte_done = mode_mii ? pack_done : dv_p0;
  assign new_byte  = mode_mii ? pack_byte : rxd_p0;
  assign bad_end   = err_flag | (mode_mii & odd_pending);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (armed && dv_p0) begin
          if (pre_bad)     state_next = DROP;
          else if (is_sfd) state_next = PAYLOAD;
          else             state_next = PREAMBLE;
        end
      end
      PREAMBLE: begin
        if (!dv_p0)       state_next = IDLE;
        else if (pre_bad) state_next = DROP;
        else if (is_sfd)  state_next = PAYLOAD;
      end
      PAYLOAD:  if (!dv_p0) state_next = IDLE;
      DROP:     if (!dv_p0) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    tvalid_d  = 1'b0;
    tlast_d   = 1'b0;
    tuser_d   = 1'b0;
    tdata_d   = hold_p1;
    start_d   = 1'b0;
    epre_d    = 1'b0;
    ebad_d    = 1'b0;
    hold_load = 1'b0;
    hold_clr  = 1'b0;
    if (pre_go) begin
      epre_d  = pre_bad;
      start_d = ~pre_bad & is_sfd;
    end
    if (state == PAYLOAD) begin
      if (dv_p0) begin
        if (byte_done) begin
          hold_load = 1'b1;
          tvalid_d  = vld_p1;
        end
      end else begin
        hold_clr = 1'b1;
        if (vld_p1) begin
          tvalid_d = 1'b1;
          tlast_d  = 1'b1;
          tuser_d  = bad_end;
          ebad_d   = bad_end;
        end else begin
          ebad_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed    <= 1'b0;
      mode_mii <= 1'b0;
      prev5    <= 1'b0;
      pre_cnt  <= '0;
      err_flag <= 1'b0;
    end else begin
      armed   <= armed | (loaded_p0 & ~dv_p0);
      prev5   <= pre_go & (rxd_p0[3:0] == MII_PRE_NIB);
      pre_cnt <= (state_next == PREAMBLE) ? cnt_inc[PRE_CNT_W-1:0] : '0;
      if (state == IDLE) mode_mii <= mii_p0;
      if (start_d)                                      err_flag <= 1'b0;
      else if ((state == PAYLOAD) && dv_p0 && er_p0)    err_flag <= 1'b1;
    end
  end

  // Stage p1: one-byte hold so the final byte can carry tlast without lookahead
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         vld_p1 <= 1'b0;
    else if (hold_clr)  vld_p1 <= 1'b0;
    else if (hold_load) vld_p1 <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (hold_load) hold_p1 <= new_byte;
  end

  // Stage p2: registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tdata    <= 8'h00;
      m_axis_tvalid   <= 1'b0;
      m_axis_tlast    <= 1'b0;
      m_axis_tuser    <= 1'b0;
      start_packet    <= 1'b0;
      error_preamble  <= 1'b0;
      error_bad_frame <= 1'b0;
    end else begin
      m_axis_tdata    <= tdata_d;
      m_axis_tvalid   <= tvalid_d;
      m_axis_tlast    <= tlast_d;
      m_axis_tuser    <= tuser_d;
      start_packet    <= start_d;
      error_preamble  <= epre_d;
      error_bad_frame <= ebad_d;
    end
  end

`ifdef GMII_RX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames     <= 32'd0;
      stat_bad_frames <= 32'd0;
    end else begin
      if (tvalid_d && tlast_d) stat_frames     <= stat_frames + 32'd1;
      if (ebad_d || epre_d)    stat_bad_frames <= stat_bad_frames + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gmii_rx_frame_align.sv
// Bench for gmii_rx_frame_align: directed frames plus random frames against a frame-level model.
module tb_gmii_rx_frame_align;

  localparam int PRE_CHECK = 1;
  localparam int MAX_PRE   = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mii_select = 1'b0;
  logic [7:0]  gmii_rxd = 8'h00;
  logic        gmii_rx_dv = 1'b0;
  logic        gmii_rx_er = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic        start_packet, error_preamble, error_bad_frame;
`ifdef GMII_RX_STATS_EN
  logic [31:0] stat_frames, stat_bad_frames;
`endif

  gmii_rx_frame_align #(.PRE_CHECK(PRE_CHECK), .MAX_PRE_BYTES(MAX_PRE)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mii_select      (mii_select),
    .gmii_rxd        (gmii_rxd),
    .gmii_rx_dv      (gmii_rx_dv),
    .gmii_rx_er      (gmii_rx_er),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tuser    (m_axis_tuser),
    .start_packet    (start_packet),
    .error_preamble  (error_preamble),
`ifdef GMII_RX_STATS_EN
    .error_bad_frame (error_bad_frame),
    .stat_frames     (stat_frames),
    .stat_bad_frames (stat_bad_frames)
`else
    .error_bad_frame (error_bad_frame)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: collects beats and pulse counts on the falling edge
  logic [9:0] obs_q[$];
  int         obs_cyc[$];
  int         obs_start = 0, obs_epre = 0, obs_ebad = 0;
  always @(negedge clk) begin
    if (m_axis_tvalid) begin
      obs_q.push_back({m_axis_tdata, m_axis_tlast, m_axis_tuser});
      obs_cyc.push_back(cyc);
    end
    if (start_packet)    obs_start++;
    if (error_preamble)  obs_epre++;
    if (error_bad_frame) obs_ebad++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int         checks = 0, errors = 0;
  int         rd = 0;
  logic [9:0] exp_q[$];
  int         exp_start = 0, exp_epre = 0, exp_ebad = 0;
  logic [7:0] tx_u[$];
  logic       tx_er[$];
  int         tx_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_u(input logic [7:0] u, input logic e);
    tx_u.push_back(u);
    tx_er.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      gmii_rx_dv = 1'b0;
      gmii_rx_er = 1'b0;
      gmii_rxd   = 8'($urandom);
      @(posedge clk); #1;
    end
  endtask

  // Drives the queued units; mode is toggled randomly mid-frame, which must be ignored.
  task automatic send(input logic mii);
    tx_cyc.delete();
    mii_select = mii;
    foreach (tx_u[i]) begin
      if (i > 0) mii_select = 1'($urandom);
      gmii_rx_dv = 1'b1;
      gmii_rx_er = tx_er[i];
      gmii_rxd   = mii ? {4'($urandom), tx_u[i][3:0]} : tx_u[i];
      tx_cyc.push_back(cyc);
      @(posedge clk); #1;
    end
  endtask

  // Frame-level reference: locate SFD under the preamble rules, then build the payload.
  task automatic model(input logic mii);
    int n, i, cnt, lim;
    logic err, found, dropped, pre_ok, sfd_ok;
    logic [7:0] pay[$];
    n = tx_u.size();
    lim = mii ? 2 * MAX_PRE : MAX_PRE;
    cnt = 0; i = 0; found = 1'b0; dropped = 1'b0;
    while (i < n && !found && !dropped) begin
      if (mii) begin
        sfd_ok = (i > 0) && (tx_u[i-1][3:0] == 4'h5) && (tx_u[i][3:0] == 4'hD);
        pre_ok = (tx_u[i][3:0] == 4'h5);
      end else begin
        sfd_ok = (tx_u[i] == 8'hD5);
        pre_ok = (tx_u[i] == 8'h55);
      end
      if (tx_er[i] || (PRE_CHECK != 0 && !pre_ok && !sfd_ok) || (!sfd_ok && cnt + 1 > lim))
        dropped = 1'b1;
      else if (sfd_ok)
        found = 1'b1;
      else
        cnt++;
      i++;
    end
    if (dropped) exp_epre++;
    if (found) begin
      exp_start++;
      err = 1'b0;
      for (int j = i; j < n; j++) if (tx_er[j]) err = 1'b1;
      if (mii) begin
        for (int j = i; j + 1 < n; j += 2) pay.push_back({tx_u[j+1][3:0], tx_u[j][3:0]});
        if (((n - i) % 2) != 0) err = 1'b1;
      end else begin
        for (int j = i; j < n; j++) pay.push_back(tx_u[j]);
      end
      if (pay.size() == 0) exp_ebad++;
      else begin
        foreach (pay[k]) exp_q.push_back({pay[k], k == pay.size() - 1, (k == pay.size() - 1) & err});
        if (err) exp_ebad++;
      end
    end
  endtask

  task automatic check_beats(input string tag);
    int nobs;
    nobs = obs_q.size() - rd;
    check({tag, "_beats"}, nobs, exp_q.size());
    for (int k = 0; k < exp_q.size() && k < nobs; k++)
      check($sformatf("%s_beat%0d", tag, k), obs_q[rd + k], exp_q[k]);
    rd = obs_q.size();
    exp_q.delete();
    check({tag, "_start"}, obs_start, exp_start);
    check({tag, "_epre"}, obs_epre, exp_epre);
    check({tag, "_ebad"}, obs_ebad, exp_ebad);
  endtask

  task automatic gmii_frame(input int npre, input int npay);
    tx_u.delete(); tx_er.delete();
    repeat (npre) push_u(8'h55, 1'b0);
    push_u(8'hD5, 1'b0);
    for (int k = 0; k < npay; k++) push_u(8'(k), 1'b0);
  endtask

  initial begin
    int   r0, nt, plen, payl;
    logic m;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tlast", m_axis_tlast, 1'b0);
    check("rst_tuser", m_axis_tuser, 1'b0);
    check("rst_tdata", m_axis_tdata, 8'h00);
    check("rst_start", start_packet, 1'b0);
    check("rst_epre", error_preamble, 1'b0);
    check("rst_ebad", error_bad_frame, 1'b0);
    rst_n = 1'b1;
    idle(3);

    // GMII 7x55 + D5 + 64 bytes, with latency check on byte 0
    gmii_frame(7, 64);
    model(1'b0);
    send(1'b0);
    idle(6);
    r0 = rd;
    if (obs_q.size() > r0) check("gmii_latency", obs_cyc[r0], tx_cyc[8] + 3);
    else check("gmii_latency_nobeat", obs_q.size(), r0 + 1);
    check_beats("gmii64");

    // MII: 15 nibbles 5, D, then 1,2,3,4
    tx_u.delete(); tx_er.delete();
    repeat (15) push_u(8'h05, 1'b0);
    push_u(8'h0D, 1'b0);
    for (int k = 1; k <= 4; k++) push_u(8'(k), 1'b0);
    model(1'b1); send(1'b1); idle(6);
    check_beats("mii4");

    // MII with a dangling odd nibble
    tx_u.delete(); tx_er.delete();
    repeat (15) push_u(8'h05, 1'b0);
    push_u(8'h0D, 1'b0);
    repeat (5) push_u(8'($urandom) & 8'h0F, 1'b0);
    model(1'b1); send(1'b1); idle(6);
    check_beats("mii_odd");

    // GMII er on payload byte 10 of 20
    gmii_frame(7, 20);
    tx_er[18] = 1'b1;
    model(1'b0); send(1'b0); idle(6);
    check_beats("gmii_er");

    // Bad preamble byte, then a good frame after a single idle cycle
    gmii_frame(7, 8);
    tx_u[2] = 8'h57;
    model(1'b0); send(1'b0); idle(1);
    gmii_frame(7, 12);
    model(1'b0); send(1'b0); idle(6);
    check_beats("bad_pre");

    // Reset asserted mid-payload: outputs clear at once, no tlast
    gmii_frame(7, 6);
    send(1'b0);
    exp_start++;
    check("mid_tvalid_before", m_axis_tvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", m_axis_tvalid, 1'b0);
    check("mid_rst_tdata", m_axis_tdata, 8'h00);
    nt = 0;
    for (int k = rd; k < obs_q.size(); k++) if (obs_q[k][1]) nt++;
    check("mid_rst_no_tlast", nt, 0);
    rd = obs_q.size();

    // Reset released while dv is already high: rest of the frame ignored
    gmii_frame(0, 14);
    for (int k = 0; k < 4; k++) begin
      gmii_rx_dv = 1'b1; gmii_rx_er = 1'b0; gmii_rxd = tx_u[k];
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    for (int k = 4; k < tx_u.size(); k++) begin
      gmii_rx_dv = 1'b1; gmii_rx_er = 1'b0; gmii_rxd = tx_u[k];
      @(posedge clk); #1;
    end
    idle(4);
    check_beats("rst_release");
    gmii_frame(7, 10);
    model(1'b0); send(1'b0); idle(6);
    check_beats("after_rst");
`ifdef GMII_RX_STATS_EN
    check("stat_frames", stat_frames, 32'd1);
    check("stat_bad_frames", stat_bad_frames, 32'd0);
`endif

    // Random frames, both modes, short gaps
    for (int f = 0; f < 40; f++) begin
      m = 1'($urandom_range(0, 1));
      tx_u.delete(); tx_er.delete();
      plen = m ? $urandom_range(1, 33) : $urandom_range(1, 17);
      repeat (plen) push_u(m ? 8'h05 : 8'h55, 1'b0);
      if ($urandom_range(0, 7) == 0)
        tx_u[$urandom_range(0, plen - 1)] = 8'($urandom) & (m ? 8'h0F : 8'hFF);
      push_u(m ? 8'h0D : 8'hD5, 1'b0);
      payl = $urandom_range(0, m ? 25 : 12);
      repeat (payl) push_u(8'($urandom) & (m ? 8'h0F : 8'hFF), 1'b0);
      foreach (tx_er[k]) if ($urandom_range(0, 29) == 0) tx_er[k] = 1'b1;
      model(m);
      send(m);
      idle($urandom_range(1, 3));
    end
    idle(8);
    check_beats("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
